// File: rtl/drop_statemachine.sv
// Connect-4 board writer: clears the board, or drops a piece into the lowest empty cell of a column and runs the win checker.
// Latency: drop to row k gives done after 2k+4 cycles plus the checker time; a clear takes 9 cycles; a full column gives col_full after 17.
// Backpressure: requests are sampled only in IDLE; busy is high otherwise and requests made while busy are dropped, not queued.
module drop_statemachine (
    input  logic        clk,
    input  logic        rst,
    input  logic        drop_req,
    input  logic [2:0]  drop_col,
    input  logic        player,
    input  logic        board_clr,
    output logic [2:0]  ram_addr,
    output logic        ram_r_en,
    input  logic [15:0] ram_r_val,
    output logic        ram_w_en,
    output logic [15:0] ram_w_val,
    output logic        check_en,
    input  logic        check_done,
    output logic        busy,
    output logic        done,
    output logic        col_full,
    output logic [2:0]  placed_row
);

    typedef enum logic [2:0] {IDLE, CLR, RD, WT, WR, CHK, FIN, REJ} state_t;

    state_t      state;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        ply;
    logic [15:0] rowbuf;

    logic [3:0]  cell_lsb;
    logic [1:0]  rd_cell;
    logic [15:0] cell_mask;
    logic [15:0] piece;
    logic [15:0] merged;

    assign cell_lsb  = {col, 1'b0};
    assign rd_cell   = ram_r_val[cell_lsb +: 2];
    assign cell_mask = 16'h0003 << cell_lsb;
    assign piece     = {14'd0, (ply ? 2'b10 : 2'b01)} << cell_lsb;
    assign merged    = (rowbuf & ~cell_mask) | piece;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= 3'd0;
            col        <= 3'd0;
            ply        <= 1'b0;
            rowbuf     <= 16'h0000;
            placed_row <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Clear wins over a simultaneous drop; the drop is discarded.
                    if (board_clr) begin
                        row   <= 3'd0;
                        state <= CLR;
                    end else if (drop_req) begin
                        col   <= drop_col;
                        ply   <= player;
                        row   <= 3'd0;
                        state <= RD;
                    end
                end
                CLR: begin
                    if (row == 3'd7) state <= FIN;
                    else             row   <= row + 3'd1;
                end
                RD:  state <= WT;
                WT: begin
                    rowbuf <= ram_r_val;
                    if (rd_cell == 2'b00) begin
                        state <= WR;
                    end else if (row == 3'd7) begin
                        state <= REJ;
                    end else begin
                        row   <= row + 3'd1;
                        state <= RD;
                    end
                end
                WR: begin
                    placed_row <= row;
                    state      <= CHK;
                end
                CHK: if (check_done) state <= FIN;
                FIN: state <= IDLE;
                REJ: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register only, so reset clears them at once.
    always_comb begin
        ram_addr  = 3'd0;
        ram_r_en  = 1'b0;
        ram_w_en  = 1'b0;
        ram_w_val = 16'h0000;
        check_en  = 1'b0;
        done      = 1'b0;
        col_full  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            CLR: begin
                ram_addr = row;
                ram_w_en = 1'b1;
            end
            RD: begin
                ram_addr = row;
                ram_r_en = 1'b1;
            end
            WR: begin
                ram_addr  = row;
                ram_w_en  = 1'b1;
                ram_w_val = merged;
            end
            CHK:     check_en = 1'b1;
            FIN:     done     = 1'b1;
            REJ:     col_full = 1'b1;
            default: ;
        endcase
    end

endmodule
